fetch_prefetch_unit: RTL

Parametrised instruction-fetch stage with an in-order prefetch slot buffer between the PC generator and decode. It issues sequential requests to instruction memory over a valid/ready request port and accepts in-order responses of arbitrary latency. It delivers instruction/PC pairs to decode through a valid/ready handshake. A redirect (PCSelector/NewPC) flushes held slots and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_slot_buffer.sv | 79 +++++++
 rtl/fetch_prefetch_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FetchPcWidth    = 32;
  localparam int unsigned FetchInstrWidth = 32;
  localparam int unsigned FetchQueueDepth = 4;

  typedef struct packed {
    logic [FetchPcWidth-1:0]    pc;
    logic [FetchInstrWidth-1:0] instr;
    logic                       filled;
  } fetch_slot_t;

  // Counters and pointers carry one extra bit so a completely full queue is representable.
  function automatic int unsigned fetch_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned FetchCntWidth = fetch_cnt_w(FetchQueueDepth);

endpackage

// File: rtl/fetch_slot_buffer.sv
// In-order slot ring: slots are allocated at issue, filled by responses in order and popped at head.
module fetch_slot_buffer import fetch_pkg::*; #(
  parameter int unsigned Depth = FetchQueueDepth,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = fetch_cnt_w(Depth)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       alloc_i,
  input  logic [FetchPcWidth-1:0]    alloc_pc_i,
  input  logic                       fill_i,
  input  logic [FetchInstrWidth-1:0] fill_data_i,
  input  logic                       pop_i,
  output fetch_slot_t                head_o,
  output logic [CntW-1:0]            count_o,
  output logic [CntW-1:0]            pending_o
);

  fetch_slot_t     slots_q [Depth];
  fetch_slot_t     slots_d [Depth];
  logic [CntW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [CntW-1:0] fill_ptr_q, fill_ptr_d;
  logic [CntW-1:0] head_ptr_q, head_ptr_d;

  always_comb begin
    slots_d     = slots_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        slots_d[i].filled = 1'b0;
      end
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
    end else begin
      // Alloc, fill and pop always address distinct slots, so their order here is irrelevant.
      if (alloc_i) begin
        slots_d[alloc_ptr_q[PtrW-1:0]].pc     = alloc_pc_i;
        slots_d[alloc_ptr_q[PtrW-1:0]].filled = 1'b0;
        alloc_ptr_d = alloc_ptr_q + CntW'(1);
      end
      if (fill_i) begin
        slots_d[fill_ptr_q[PtrW-1:0]].instr  = fill_data_i;
        slots_d[fill_ptr_q[PtrW-1:0]].filled = 1'b1;
        fill_ptr_d = fill_ptr_q + CntW'(1);
      end
      if (pop_i) begin
        slots_d[head_ptr_q[PtrW-1:0]].filled = 1'b0;
        head_ptr_d = head_ptr_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        slots_q[i] <= '0;
      end
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
    end else begin
      slots_q     <= slots_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
    end
  end

  always_comb begin
    head_o    = slots_q[head_ptr_q[PtrW-1:0]];
    count_o   = alloc_ptr_q - head_ptr_q;
    pending_o = alloc_ptr_q - fill_ptr_q;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: sequential PC generation, prefetch slot buffer and redirect handling
// that drops responses to requests issued before the redirect.
module fetch_prefetch_unit import fetch_pkg::*; #(
  parameter int unsigned          PC_WIDTH          = FetchPcWidth,
  parameter int unsigned          INSTRUCTION_WIDTH = FetchInstrWidth,
  parameter int unsigned          QUEUE_DEPTH       = FetchQueueDepth,
  parameter int unsigned          PC_STEP           = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC          = '0,
  localparam int unsigned         CntW              = fetch_cnt_w(QUEUE_DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         PCSelector,
  input  logic [PC_WIDTH-1:0]          NewPC,
  output logic                         imem_req_valid,
  output logic [PC_WIDTH-1:0]          imem_req_addr,
  input  logic                         imem_req_ready,
  input  logic                         imem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
  output logic                         instruction_valid,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          instruction_pc,
  input  logic                         decode_ready,
  output logic [CntW-1:0]              queue_count
);

  localparam logic [CntW:0] DepthOcc = (CntW+1)'(QUEUE_DEPTH);
  localparam logic [CntW:0] OneOcc   = (CntW+1)'(1);

  if (PC_WIDTH != FetchPcWidth || INSTRUCTION_WIDTH != FetchInstrWidth ||
      QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_params
    $error("fetch_prefetch_unit: widths must match fetch_pkg and depth must be a power of two");
  end

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]     drop_count_q, drop_count_d;
  logic [CntW-1:0]     pending;
  logic [CntW:0]       occupancy;
  logic [CntW:0]       drop_sum;
  logic                issue, fill, drop_resp, pop;
  fetch_slot_t         head;

  always_comb begin
    occupancy         = {1'b0, queue_count} + {1'b0, drop_count_q};
    imem_req_valid    = enable & ~PCSelector & (occupancy < DepthOcc);
    imem_req_addr     = fetch_pc_q;
    issue             = imem_req_valid & imem_req_ready;
    drop_resp         = imem_resp_valid & (drop_count_q != '0);
    fill              = imem_resp_valid & (drop_count_q == '0) & (pending != '0) & ~PCSelector;
    instruction_valid = head.filled & ~PCSelector;
    instruction       = head.instr;
    instruction_pc    = head.pc;
    pop               = instruction_valid & decode_ready;

    fetch_pc_d   = fetch_pc_q;
    drop_count_d = drop_count_q;
    drop_sum     = '0;
    if (PCSelector) begin
      // Every unfilled slot still owes a response; one arriving now is already accounted for.
      fetch_pc_d = NewPC;
      drop_sum   = {1'b0, drop_count_q} + {1'b0, pending};
      if (imem_resp_valid && drop_sum != '0) begin
        drop_sum = drop_sum - OneOcc;
      end
      drop_count_d = drop_sum[CntW-1:0];
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_STEP);
      end
      if (drop_resp) begin
        drop_count_d = drop_count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      drop_count_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      drop_count_q <= drop_count_d;
    end
  end

  fetch_slot_buffer #(
    .Depth (QUEUE_DEPTH)
  ) u_slots (
    .clk_i       (clock),
    .rst_ni      (reset),
    .flush_i     (PCSelector),
    .alloc_i     (issue),
    .alloc_pc_i  (fetch_pc_q),
    .fill_i      (fill),
    .fill_data_i (imem_resp_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (queue_count),
    .pending_o   (pending)
  );

`ifndef SYNTHESIS
  // A response must belong either to an allocated slot or to a request orphaned by a redirect.
  resp_owned_a: assert property (@(posedge clock) disable iff (!reset)
    imem_resp_valid |-> (drop_count_q != '0 || pending != '0));
  occupancy_a: assert property (@(posedge clock) disable iff (!reset) occupancy <= DepthOcc);
`endif

endmodule
